mux_arbiter: RTL

- Two-requester round-robin arbiter and scheduler for the team's 2:1 mux datapath.
- Each beat, it decides which source (data_0 or data_1) may pass, and drives the selector.
- The chosen beat is registered into a single output stage with a valid/ready handshake.
- Sits between two producer blocks and one shared downstream consumer.

---
 rtl/mux_arbiter_pkg.sv | 16 +
 rtl/mux_arbiter_pick.sv | 37 +++
 rtl/mux_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mux_arbiter_pkg.sv
// Shared types for the 2:1 round-robin mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_e FSM encoding (IDLE/GNT0/GNT1) and the SRC_0/SRC_1 source indices.
package mux_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_e;

   localparam logic SRC_0 = 1'b0;
   localparam logic SRC_1 = 1'b1;

endpackage

// File: rtl/mux_arbiter_pick.sv
// Round-robin pick between two requesters; honours a burst lock when one is held.
// Latency: purely combinational.
// Backpressure: none here; the top qualifies the pick with its can-accept term.
// Ports: valid_0/valid_1 requests, last_served (source granted most recently),
//        lock/lock_src (grant pinned to lock_src), pick (chosen source), pick_valid.
module mux_arbiter_pick
   import mux_arbiter_pkg::*;
(
   input  logic valid_0,
   input  logic valid_1,
   input  logic last_served,
   input  logic lock,
   input  logic lock_src,
   output logic pick,
   output logic pick_valid
);

   always_comb begin
      pick       = SRC_0;
      pick_valid = 1'b0;
      if (lock) begin
         // A locked burst ignores the other source, even if the owner idles.
         pick       = lock_src;
         pick_valid = lock_src ? valid_1 : valid_0;
      end else if (valid_0 && valid_1) begin
         pick       = ~last_served;
         pick_valid = 1'b1;
      end else if (valid_0) begin
         pick       = SRC_0;
         pick_valid = 1'b1;
      end else if (valid_1) begin
         pick       = SRC_1;
         pick_valid = 1'b1;
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux into one registered output stage.
// Latency: a beat accepted in cycle t appears on data_out in cycle t+1; one beat/cycle max.
// Backpressure: ready_0/ready_1 low while out_valid && !out_ready; output holds.
// Ports: clk, reset (async, active-low); valid_N/data_N/ready_N per source;
//        selector (current pick); data_out/out_valid/out_ready/out_src to the consumer.
// Optional: MUX_ARBITER_BURST_EN adds last_0/last_1 and locks the grant until a burst ends.
module mux_arbiter
   import mux_arbiter_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_0,
   input  logic [WIDTH-1:0] data_0,
   output logic             ready_0,
   input  logic             valid_1,
   input  logic [WIDTH-1:0] data_1,
   output logic             ready_1,
`ifdef MUX_ARBITER_BURST_EN
   input  logic             last_0,
   input  logic             last_1,
`endif
   output logic             selector,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src
);

   state_e           state_q, state_d;
   logic             last_served_q, last_served_d;
   logic             vld_q, vld_d;
   logic             src_q, src_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sel_q, sel_d;
   logic             lock, lock_src;
   logic             pick, pick_valid;
   logic             can_accept;
   logic             accept;

`ifdef MUX_ARBITER_BURST_EN
   logic lock_q, lock_d;
   logic lock_src_q, lock_src_d;
   logic acc_last;

   assign lock     = lock_q;
   assign lock_src = lock_src_q;
   assign acc_last = pick ? last_1 : last_0;
`else
   assign lock     = 1'b0;
   assign lock_src = SRC_0;
`endif

   mux_arbiter_pick u_pick (
      .valid_0     (valid_0),
      .valid_1     (valid_1),
      .last_served (last_served_q),
      .lock        (lock),
      .lock_src    (lock_src),
      .pick        (pick),
      .pick_valid  (pick_valid)
   );

   assign can_accept = !vld_q || out_ready;
   // Gating with reset keeps both readies low for the whole reset window.
   assign ready_0    = reset && can_accept && pick_valid && (pick == SRC_0);
   assign ready_1    = reset && can_accept && pick_valid && (pick == SRC_1);
   assign accept     = ready_0 || ready_1;

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      vld_d         = vld_q;
      src_d         = src_q;
      data_d        = data_q;
      sel_d         = pick_valid ? pick : sel_q;
`ifdef MUX_ARBITER_BURST_EN
      lock_d        = lock_q;
      lock_src_d    = lock_src_q;
`endif
      if (accept) begin
         // Covers simultaneous drain+accept: the new beat replaces the old one.
         data_d  = pick ? data_1 : data_0;
         src_d   = pick;
         vld_d   = 1'b1;
         state_d = pick ? GNT1 : GNT0;
`ifdef MUX_ARBITER_BURST_EN
         if (acc_last) begin
            lock_d        = 1'b0;
            last_served_d = pick;
         end else begin
            lock_d     = 1'b1;
            lock_src_d = pick;
         end
`else
         last_served_d = pick;
`endif
      end else if (vld_q && out_ready) begin
         vld_d   = 1'b0;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_served_q <= SRC_1;
         vld_q         <= 1'b0;
         src_q         <= SRC_0;
         data_q        <= '0;
         sel_q         <= SRC_0;
`ifdef MUX_ARBITER_BURST_EN
         lock_q        <= 1'b0;
         lock_src_q    <= SRC_0;
`endif
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         vld_q         <= vld_d;
         src_q         <= src_d;
         data_q        <= data_d;
         sel_q         <= sel_d;
`ifdef MUX_ARBITER_BURST_EN
         lock_q        <= lock_d;
         lock_src_q    <= lock_src_d;
`endif
      end
   end

   assign selector  = sel_d;
   assign data_out  = data_q;
   assign out_valid = vld_q;
   assign out_src   = src_q;

endmodule
